// File: rtl/magma_pkg.sv
// Shared constants, S-box table and subkey schedule for the Magma cipher.
package magma_pkg;

  localparam int ROUNDS  = 32;
  localparam int BLOCK_W = 64;
  localparam int KEY_W   = 256;
  localparam int HALF_W  = 32;

  typedef enum logic {IDLE, RUN} state_t;

  // Row n substitutes nibble n (row 0 -> bits [3:0]).
  localparam logic [3:0] SBOX [8][16] = '{
    '{4'hC, 4'h4, 4'h6, 4'h2, 4'hA, 4'h5, 4'hB, 4'h9, 4'hE, 4'h8, 4'hD, 4'h7, 4'h0, 4'h3, 4'hF, 4'h1},
    '{4'h6, 4'h8, 4'h2, 4'h3, 4'h9, 4'hA, 4'h5, 4'hC, 4'h1, 4'hE, 4'h4, 4'h7, 4'hB, 4'hD, 4'h0, 4'hF},
    '{4'hB, 4'h3, 4'h5, 4'h8, 4'h2, 4'hF, 4'hA, 4'hD, 4'hE, 4'h1, 4'h7, 4'h4, 4'hC, 4'h9, 4'h6, 4'h0},
    '{4'hC, 4'h8, 4'h2, 4'h1, 4'hD, 4'h4, 4'hF, 4'h6, 4'h7, 4'h0, 4'hA, 4'h5, 4'h3, 4'hE, 4'h9, 4'hB},
    '{4'h7, 4'hF, 4'h5, 4'hA, 4'h8, 4'h1, 4'h6, 4'hD, 4'h0, 4'h9, 4'h3, 4'hE, 4'hB, 4'h4, 4'h2, 4'hC},
    '{4'h5, 4'hD, 4'hF, 4'h6, 4'h9, 4'h2, 4'hC, 4'hA, 4'hB, 4'h7, 4'h8, 4'h1, 4'h4, 4'h3, 4'hE, 4'h0},
    '{4'h8, 4'hE, 4'h2, 4'h5, 4'h6, 4'h9, 4'h1, 4'hC, 4'hF, 4'h4, 4'hB, 4'h0, 4'hD, 4'hA, 4'h3, 4'h7},
    '{4'h1, 4'h7, 4'hE, 4'hD, 4'h0, 4'h5, 4'h8, 4'h3, 4'h4, 4'hF, 4'hA, 4'h6, 4'h9, 4'hC, 4'hB, 4'h2}
  };

  // rnd is the zero-based round number; returns zero-based key word (0 = K1).
  function automatic logic [2:0] subkey_idx(input logic [5:0] rnd);
    if (rnd < 6'd24) return rnd[2:0];
    else             return 3'(6'd31 - rnd);
  endfunction

endpackage

// File: rtl/magma_round.sv
// One combinational Magma Feistel round; the final round skips the half swap.
module magma_round
  import magma_pkg::*;
(
  input  logic [HALF_W-1:0] a1,
  input  logic [HALF_W-1:0] a0,
  input  logic [HALF_W-1:0] subkey,
  input  logic              last_round,
  output logic [HALF_W-1:0] next_a1,
  output logic [HALF_W-1:0] next_a0
);

  logic [HALF_W-1:0] sum;
  logic [HALF_W-1:0] sub;
  logic [HALF_W-1:0] g;

  always_comb begin
    sum = a0 + subkey;
    sub = '0;
    for (int n = 0; n < 8; n++) begin
      sub[4*n +: 4] = SBOX[n][sum[4*n +: 4]];
    end
    g = {sub[20:0], sub[31:21]};
    if (last_round) begin
      next_a1 = g ^ a1;
      next_a0 = a0;
    end else begin
      next_a1 = a0;
      next_a0 = g ^ a1;
    end
  end

endmodule

// File: rtl/magma_cipher.sv
// Two-block Magma ECB encryptor: one round per clock on both blocks, done 32 cycles after start.
// start is ignored while busy; all outputs are registered.
module magma_cipher
  import magma_pkg::*;
#(
  parameter int ROUNDS = 32
) (
  input  logic                 clk,
  input  logic                 reset_,
  input  logic                 start,
  input  logic [2*BLOCK_W-1:0] data_in,
  input  logic [KEY_W-1:0]     key,
  output logic [2*BLOCK_W-1:0] data_out,
  output logic                 done,
  output logic                 busy
);

  state_t             state;
  state_t             state_nxt;
  logic [5:0]         rnd;
  logic [BLOCK_W-1:0] blk_a;
  logic [BLOCK_W-1:0] blk_b;
  logic [BLOCK_W-1:0] nxt_a;
  logic [BLOCK_W-1:0] nxt_b;
  logic [KEY_W-1:0]   key_r;
  logic [HALF_W-1:0]  key_words [8];
  logic [HALF_W-1:0]  subkey;
  logic               load;
  logic               last;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          load      = 1'b1;
        end
      end
      RUN: begin
        if (rnd == 6'(ROUNDS - 1)) begin
          state_nxt = IDLE;
          last      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    for (int j = 0; j < 8; j++) begin
      key_words[j] = key_r[KEY_W-1-HALF_W*j -: HALF_W];
    end
  end

  assign subkey = key_words[subkey_idx(rnd)];

  magma_round u_round_a (
    .a1         (blk_a[BLOCK_W-1:HALF_W]),
    .a0         (blk_a[HALF_W-1:0]),
    .subkey     (subkey),
    .last_round (last),
    .next_a1    (nxt_a[BLOCK_W-1:HALF_W]),
    .next_a0    (nxt_a[HALF_W-1:0])
  );

  magma_round u_round_b (
    .a1         (blk_b[BLOCK_W-1:HALF_W]),
    .a0         (blk_b[HALF_W-1:0]),
    .subkey     (subkey),
    .last_round (last),
    .next_a1    (nxt_b[BLOCK_W-1:HALF_W]),
    .next_a0    (nxt_b[HALF_W-1:0])
  );

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state    <= IDLE;
      rnd      <= '0;
      blk_a    <= '0;
      blk_b    <= '0;
      key_r    <= '0;
      data_out <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      if (load) begin
        blk_a <= data_in[2*BLOCK_W-1:BLOCK_W];
        blk_b <= data_in[BLOCK_W-1:0];
        key_r <= key;
        rnd   <= '0;
        busy  <= 1'b1;
      end else if (state == RUN) begin
        blk_a <= nxt_a;
        blk_b <= nxt_b;
        rnd   <= rnd + 6'd1;
        // The final round's output goes straight to data_out.
        if (last) begin
          data_out <= {nxt_a, nxt_b};
          done     <= 1'b1;
          busy     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_magma_cipher.sv
// Scoreboard bench for magma_cipher: driver queues reference results, a monitor checks every done pulse.
module tb_magma_cipher;

  logic         clk;
  logic         reset_;
  logic         start;
  logic [127:0] data_in;
  logic [255:0] key;
  logic [127:0] data_out;
  logic         done;
  logic         busy;

  typedef struct {
    logic [127:0] dat;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           checks;
  int           errors;
  int           cyc;
  logic [127:0] last_exp;

  localparam logic [255:0] STD_KEY = 256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [63:0]  STD_PT  = 64'hfedcba9876543210;
  localparam logic [63:0]  STD_CT  = 64'h4ee901e5c2d8ca3d;

  magma_cipher dut (
    .clk      (clk),
    .reset_   (reset_),
    .start    (start),
    .data_in  (data_in),
    .key      (key),
    .data_out (data_out),
    .done     (done),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Substitution rows as hex strings, entry 0 in the top nibble.
  function automatic logic [63:0] pi_row(input int n);
    case (n)
      0: return 64'hc462a5b9e8d703f1;
      1: return 64'h68239a5c1e47bd0f;
      2: return 64'hb3582fade174c960;
      3: return 64'hc821d4f670a53e9b;
      4: return 64'h7f5a816d093eb42c;
      5: return 64'h5df692cab78143e0;
      6: return 64'h8e25691cf4b0da37;
      default: return 64'h17ed05834fa69cb2;
    endcase
  endfunction

  function automatic logic [63:0] ref_enc(input logic [63:0] blk, input logic [255:0] k);
    logic [31:0] a1;
    logic [31:0] a0;
    logic [31:0] t;
    logic [31:0] s;
    logic [31:0] g;
    logic [63:0] row;
    logic [3:0]  v;
    int          ki;
    a1 = blk[63:32];
    a0 = blk[31:0];
    for (int i = 1; i <= 32; i++) begin
      ki = (i <= 24) ? (i - 1) % 8 : 32 - i;
      t  = a0 + k[255-32*ki -: 32];
      s  = 32'd0;
      for (int n = 0; n < 8; n++) begin
        row = pi_row(n);
        v   = t[4*n +: 4];
        s   = s | ({28'd0, row[63-4*v -: 4]} << (4*n));
      end
      g = (s << 11) | (s >> 21);
      if (i < 32) begin
        t  = a0;
        a0 = g ^ a1;
        a1 = t;
      end else begin
        return {g ^ a1, a0};
      end
    end
    return 64'd0;
  endfunction

  function automatic logic [127:0] rand128();
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", nm, act, req, $time);
    end
  endtask

  // Drive start now; the next rising edge is the accepting edge, so queue the reference there.
  task automatic issue(input logic [127:0] d, input logic [255:0] k);
    exp_t e;
    data_in = d;
    key     = k;
    start   = 1'b1;
    @(posedge clk);
    #1;
    e.dat = {ref_enc(d[127:64], k), ref_enc(d[63:0], k)};
    e.cyc = cyc;
    sb.push_back(e);
    start = 1'b0;
  endtask

  task automatic start_op(input logic [127:0] d, input logic [255:0] k);
    @(negedge clk);
    issue(d, k);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    chk("timeout_pending", 128'(sb.size()), 128'd0);
    @(negedge clk);
  endtask

  initial begin
    logic exp_busy;
    exp_t e;
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    reset_  = 1'b0;
    start   = 1'b0;
    data_in = '0;
    key     = '0;
    last_exp = '0;

    fork
      forever begin
        @(negedge clk);
        if (reset_) begin
          exp_busy = (sb.size() != 0) && !done;
          if (done) begin
            if (sb.size() == 0) begin
              chk("spurious_done", 128'(done), 128'd0);
            end else begin
              e = sb.pop_front();
              chk("data_out", data_out, e.dat);
              chk("latency", 128'(cyc - e.cyc), 128'd32);
              last_exp = e.dat;
            end
          end
          chk("busy", 128'(busy), 128'(exp_busy));
        end
      end
      begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("reset_data_out", data_out, 128'd0);
    chk("reset_done", 128'(done), 128'd0);
    chk("reset_busy", 128'(busy), 128'd0);

    // Start coincident with the first edge after reset release.
    @(negedge clk);
    reset_ = 1'b1;
    issue({STD_PT, STD_PT}, STD_KEY);
    wait_idle();
    chk("std_vector", data_out, {STD_CT, STD_CT});

    start_op({STD_PT, 64'd0}, STD_KEY);
    wait_idle();
    chk("indep_upper", 128'(data_out[127:64]), 128'(STD_CT));

    repeat (5) @(negedge clk);
    chk("hold", data_out, last_exp);

    for (int n = 0; n < 6; n++) begin
      start_op(rand128(), rand256());
      wait_idle();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Inputs change and start pulses mid-run; the captured operands must win.
    start_op(rand128(), rand256());
    repeat (10) @(posedge clk);
    @(negedge clk);
    data_in = rand128();
    key     = rand256();
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();
    repeat (40) @(negedge clk);

    // Reset after round 16.
    start_op(rand128(), rand256());
    repeat (16) @(posedge clk);
    #2;
    reset_ = 1'b0;
    sb.delete();
    #1;
    chk("abort_data_out", data_out, 128'd0);
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_done", 128'(done), 128'd0);
    repeat (3) @(negedge clk);
    reset_ = 1'b1;
    repeat (40) @(negedge clk);
    start_op({STD_PT, STD_PT}, STD_KEY);
    wait_idle();

    // start held high: a new operation every 33 cycles.
    @(negedge clk);
    data_in = rand128();
    key     = rand256();
    start   = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk);
      #1;
      e.dat = {ref_enc(data_in[127:64], key), ref_enc(data_in[63:0], key)};
      e.cyc = cyc;
      sb.push_back(e);
      @(negedge clk);
      data_in = rand128();
      key     = rand256();
      repeat (32) @(posedge clk);
    end
    #1;
    start = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
